// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: asynchronous 8N1 UART receiver with start-glitch rejection, framing-error flag and break suppression.
// Latency: pin falling edge to rx_ready/ferr is 3+H+9N cycles (H = N/2), plus 1 when UART_RX_MAJORITY_EN is defined.
// Backpressure: none; rx_ready and ferr are single-cycle strobes that the consumer must accept.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous, active-high reset
//   rxd      - asynchronous serial line, idles high
//   rx_ready - one-cycle pulse when a byte with a valid stop bit has been received
//   rdata    - received byte, valid with rx_ready and held until the next valid byte
//   ferr     - one-cycle pulse when the stop bit is sampled low
//
// Optional build macro: UART_RX_MAJORITY_EN
//   When defined, every sample decision is the 2-of-3 majority of rxd_s at S-1, S and S+1,
//   taken at S+1, so all sample points and outputs shift one cycle later.

module uart_rx #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_ready,
    output logic [7:0] rdata,
    output logic       ferr
);

    localparam int CW = $clog2(CLK_PER_BIT) + 1;
    localparam int H  = CLK_PER_BIT / 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    // The counter reads 0 in the first cycle after t0, so the start sample at
    // t0+H sees H-1, and every later sample point (counter reloaded to 0 right
    // after the previous one) sees N-1. With majority voting the decision is
    // taken one cycle later; only the first threshold moves, the reload at
    // S+1 then keeps the bit spacing at exactly N.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] FIRST_LAST = CW'(H);
`else
    localparam logic [CW-1:0] FIRST_LAST = CW'(H - 1);
`endif
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);

    logic          rxd_m;
    logic          rxd_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          samp;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist[0] holds rxd_s of the previous cycle (S), hist[1] the one before (S-1).
    logic [1:0] hist;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rxd_s};
        end
    end

    assign samp = (rxd_s & hist[0]) | (rxd_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign samp = rxd_s;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            rdata    <= 8'h00;
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == FIRST_LAST) begin
                        cnt <= '0;
                        // A line back high by mid-start-bit is a glitch, not a frame.
                        if (!samp) begin
                            state   <= S_DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        // LSB arrives first and ends up in bit 0 after 8 shifts.
                        shreg <= {samp, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (samp) begin
                            rdata    <= shreg;
                            rx_ready <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            ferr  <= 1'b1;
                            state <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line so it cannot be read as 0x00 frames.
                    cnt <= '0;
                    if (rxd_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed self-checking bench for uart_rx at CLK_PER_BIT = 16.
// Latency: expected pulse cycle is pin-edge + 3 + H + 9N (+1 with UART_RX_MAJORITY_EN).
// Backpressure: none; a negedge monitor logs every rx_ready/ferr cycle for the scenario tasks.

module tb_uart_rx;

    localparam int N = 16;
    localparam int H = N / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 4 + H + 9 * N;
`else
    localparam int LAT = 3 + H + 9 * N;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxd   = 1'b1;
    logic       rx_ready;
    logic [7:0] rdata;
    logic       ferr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int         rdy_cyc[$];
    logic [7:0] rdy_dat[$];
    int         ferr_cyc[$];
    int         both_cnt = 0;

    uart_rx #(.CLK_PER_BIT(N)) dut (
        .clock    (clock),
        .reset    (reset),
        .rxd      (rxd),
        .rx_ready (rx_ready),
        .rdata    (rdata),
        .ferr     (ferr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rx_ready) begin
            rdy_cyc.push_back(cyc);
            rdy_dat.push_back(rdata);
        end
        if (ferr) ferr_cyc.push_back(cyc);
        if (rx_ready && ferr) both_cnt++;
    end

    task automatic clear_mon();
        rdy_cyc.delete();
        rdy_dat.delete();
        ferr_cyc.delete();
    endtask

    // All drivers start and end at posedge+1.
    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (N) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, output int p);
        p = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    // Frame whose line is inverted for one cycle exactly at each data-bit sample point.
    task automatic send_frame_inv(input logic [7:0] b, output int p);
        logic v;
        p = cyc;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < N; c++) begin
                if (k == 0)      v = 1'b0;
                else if (k == 9) v = 1'b1;
                else             v = b[k-1];
                if (k >= 1 && k <= 8 && c == H) v = ~v;
                rxd = v;
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic check_one_byte(input string name, input logic [7:0] exp, input int exp_cyc);
        n_tests++;
        if (rdy_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL %s_count: got %0d pulses, expected 1", name, rdy_cyc.size());
        end else begin
            n_tests++;
            if (rdy_dat[0] !== exp) begin
                n_fail++;
                $display("FAIL %s_data: got %02h, expected %02h", name, rdy_dat[0], exp);
            end
            n_tests++;
            if (rdy_cyc[0] !== exp_cyc) begin
                n_fail++;
                $display("FAIL %s_cycle: got %0d, expected %0d", name, rdy_cyc[0], exp_cyc);
            end
        end
        n_tests++;
        if (ferr_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_ferr: got %0d ferr pulses, expected 0", name, ferr_cyc.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_tests++;
        if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b, expected 0", rx_ready); end
        n_tests++;
        if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, expected 0", ferr); end
        n_tests++;
        if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %02h, expected 00", rdata); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_mon();
        idle(2 * N);
        n_tests++;
        if (rdy_cyc.size() + ferr_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_idle_quiet: got %0d pulses, expected 0", rdy_cyc.size() + ferr_cyc.size());
        end
    endtask

    task automatic test_single_byte();
        int p;
        clear_mon();
        send_frame(8'h55, 1'b1, p);
        idle(N);
        check_one_byte("single_55", 8'h55, p + LAT);
    endtask

    task automatic test_back_to_back();
        int p1, p2;
        clear_mon();
        send_frame(8'hA5, 1'b1, p1);
        send_frame(8'h3C, 1'b1, p2);
        idle(N);
        n_tests++;
        if (rdy_cyc.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, expected 2", rdy_cyc.size());
        end else begin
            n_tests++;
            if (rdy_dat[0] !== 8'hA5) begin n_fail++; $display("FAIL b2b_data0: got %02h, expected a5", rdy_dat[0]); end
            n_tests++;
            if (rdy_dat[1] !== 8'h3C) begin n_fail++; $display("FAIL b2b_data1: got %02h, expected 3c", rdy_dat[1]); end
            n_tests++;
            if (rdy_cyc[0] !== p1 + LAT) begin n_fail++; $display("FAIL b2b_cycle0: got %0d, expected %0d", rdy_cyc[0], p1 + LAT); end
            n_tests++;
            if (rdy_cyc[1] - rdy_cyc[0] !== 10 * N) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d, expected %0d", rdy_cyc[1] - rdy_cyc[0], 10 * N);
            end
        end
    endtask

    task automatic test_glitch();
        int p;
        clear_mon();
        rxd = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        idle(3 * N);
        n_tests++;
        if (rdy_cyc.size() + ferr_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL glitch_quiet: got %0d pulses, expected 0", rdy_cyc.size() + ferr_cyc.size());
        end
        clear_mon();
        send_frame(8'h01, 1'b1, p);
        idle(N);
        check_one_byte("glitch_then_01", 8'h01, p + LAT);
    endtask

    task automatic test_framing();
        int p;
        clear_mon();
        send_frame(8'h12, 1'b1, p);
        idle(N);
        check_one_byte("pre_ferr_12", 8'h12, p + LAT);
        clear_mon();
        send_frame(8'h81, 1'b0, p);
        rxd = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        idle(2 * N);
        n_tests++;
        if (ferr_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d, expected 1", ferr_cyc.size());
        end else begin
            n_tests++;
            if (ferr_cyc[0] !== p + LAT) begin n_fail++; $display("FAIL ferr_cycle: got %0d, expected %0d", ferr_cyc[0], p + LAT); end
        end
        n_tests++;
        if (rdy_cyc.size() !== 0) begin n_fail++; $display("FAIL ferr_no_ready: got %0d pulses, expected 0", rdy_cyc.size()); end
        n_tests++;
        if (rdata !== 8'h12) begin n_fail++; $display("FAIL ferr_rdata_held: got %02h, expected 12", rdata); end
        clear_mon();
        send_frame(8'h7E, 1'b1, p);
        idle(N);
        check_one_byte("post_ferr_7e", 8'h7E, p + LAT);
    endtask

    task automatic test_reset_midframe();
        int p;
        clear_mon();
        fork
            send_frame(8'hFF, 1'b1, p);
            begin
                repeat (5 * N + H) @(posedge clock);
                #1;
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
            end
        join
        idle(N);
        n_tests++;
        if (rdy_cyc.size() + ferr_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got %0d pulses, expected 0", rdy_cyc.size() + ferr_cyc.size());
        end
        n_tests++;
        if (rdata !== 8'h00) begin n_fail++; $display("FAIL midreset_rdata: got %02h, expected 00", rdata); end
        clear_mon();
        send_frame(8'h99, 1'b1, p);
        idle(N);
        check_one_byte("after_reset_99", 8'h99, p + LAT);
    endtask

    task automatic test_sample_inversion();
        int p;
        clear_mon();
        send_frame_inv(8'h55, p);
        idle(N);
`ifdef UART_RX_MAJORITY_EN
        check_one_byte("inv_majority", 8'h55, p + LAT);
`else
        check_one_byte("inv_single", 8'hAA, p + LAT);
`endif
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_sample_inversion();
        n_tests++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL ready_ferr_overlap: got %0d cycles, expected 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous 8N1 UART receiver that recovers bytes from the serial input pin and presents each one as a single-cycle `rx_ready` strobe with `rdata` valid in the same cycle. It sits directly upstream of the DMA/program-loader stage and drives that stage's `rx_ready`/`rdata` inputs unmodified. It also flags framing errors and rejects start-bit glitches.

## Interface
- `CLK_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 8. Counter width is `$clog2(CLK_PER_BIT)+1`.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `rxd`  in  1  serial line; asynchronous; idles high.
- `rx_ready`  out  1  one-cycle pulse when a byte with a valid stop bit is received.
- `rdata`  out  8  received byte. Valid when `rx_ready`=1; held until the next valid byte.
- `ferr`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- Synchronizer:
  - `rxd` passes through 2 flops to form `rxd_s`.
  - Both flops reset to 1.
  - All logic below uses `rxd_s` only.
- Let N = `CLK_PER_BIT` and H = floor(N/2).
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - When `rxd_s`=0, go to START and clear the counter. This cycle is t0.
- START:
  - At t0+H, sample the line.
  - Sample 0: go to DATA and set bit index to 0.
  - Sample 1: treat as a glitch and return to IDLE. No output.
- DATA:
  - Bit i (i = 0..7) is sampled at t0+H+(i+1)·N.
  - Bits shift into the shift register LSB first.
  - After bit 7, go to STOP.
- STOP:
  - Sample at t0+H+9·N.
  - Sample 1: load `rdata` from the shift register, pulse `rx_ready`, go to IDLE. A new start edge is accepted from the very next cycle, so back-to-back frames work.
  - Sample 0: pulse `ferr`, leave `rdata` unchanged, go to BREAK.
- BREAK:
  - Stay until `rxd_s`=1, then go to IDLE. This prevents a held-low line (break) from producing phantom 0x00 bytes.
- Counter:
  - Increments every cycle outside IDLE/BREAK.
  - Resets to 0 at each sample point.
  - Never wraps: its width covers N.
- `rx_ready` and `ferr` are never high in the same cycle. Neither stays high for more than 1 cycle.
- Reset (including mid-frame):
  - state=IDLE, counter=0, shift register=0.
  - `rdata`=8'h00, `rx_ready`=0, `ferr`=0.
  - Synchronizer flops=1.
  - A frame that was in progress is discarded. No pulse is emitted.

## Timing
- Pin to `rxd_s`: 2 cycles.
- Outputs are registered. `rx_ready`/`ferr` go high in cycle t0+H+9·N+1 and low the next cycle.
- `rdata` updates in the same cycle `rx_ready` rises.
- Total pin-falling-edge to `rx_ready`: 2+H+9·N+1 cycles, i.e. 3+H+9N (without the majority option).
- There is no back-pressure. The consumer must accept each pulse. The minimum spacing between `rx_ready` pulses is about 10·N − H cycles.
- Tolerated baud mismatch: about ±4% (±2% with a 2-flop sampling uncertainty budget).

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each sample decision (start check, data bits, stop bit) is the majority of `rxd_s` at the nominal sample cycle S−1, S and S+1.
  - The decision is taken at S+1, so every sample point and every output moves 1 cycle later: `rx_ready` at t0+H+9·N+2.
  - The counter reload happens at S+1, with the following interval set to N−1, so bit spacing stays N.
- Undefined:
  - Single sample at S.
  - Timing exactly as stated above.

## Test plan
- Single byte: N=16, drive 0x55 (8N1, line idle high before and after) → exactly one `rx_ready` pulse, `rdata`=8'h55, at pin-edge+3+8+144 cycles, with `ferr`=0 throughout.
- Back-to-back: 0xA5 immediately followed by 0x3C, no idle gap → two pulses with `rdata`=8'hA5 then 8'h3C, 160 cycles apart.
- Glitch: at N=16, a 3-cycle low pulse on an idle line → no `rx_ready`, no `ferr`, and state returns to IDLE; a following 0x01 frame is received correctly.
- Framing error:
  - Send 0x12 correctly, then 0x81 with the stop bit low, holding the line low 40 more cycles → `ferr` pulse, no `rx_ready`, `rdata` stays 8'h12, no further pulses during the low hold.
  - Then 0x7E → `rdata`=8'h7E.
- Reset mid-frame: assert `reset` 1 cycle during bit 4 of 0xFF → no pulse, `rdata`=8'h00; a following 0x99 frame is received correctly.
- With `UART_RX_MAJORITY_EN`:
  - 0x55 with a single-cycle inversion at each nominal sample point → `rdata`=8'h55, `rx_ready` one cycle later than the unoptioned build.
  - Without the macro, the same stimulus → corrupted byte.
